if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the single-cycle-to-pipelined MIPS datapath.
- Owns the PC register and drives the combinational instruction ROM address; captures the returned word into the IF/ID latch consumed by decode.
- Handles sequential fetch, beq-style branch redirect, j-type jump redirect, stall, flush and an out-of-range halt.
- Keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- ROM_WORDS, 32, instruction ROM depth in words; a fetch at PC >= ROM_WORDS*4 is out of range.
- CNT_W, 16, width of fetch_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID latch (load-use hazard from decode).
- branch_taken  in  1  decode has resolved a taken branch this cycle.
- branch_imm  in  16  signed word offset of that branch.
- jump  in  1  decode holds a j instruction this cycle.
- jump_index  in  26  j-type target index.
- halt_clr  in  1  leave HALT and restart at RESET_PC.
- inst_in  in  32  word returned by ROM for pc_addr (combinational, same cycle).
- pc_addr  out  32  current PC, drives ROM addr.
- ifid_inst  out  32  latched instruction to decode.
- ifid_pc4  out  32  latched PC+4 of that instruction.
- ifid_valid  out  1  ifid_inst is a real fetch (0 = bubble).
- halted  out  1  high in HALT state.
- fetch_count  out  CNT_W  number of instructions latched valid since reset.

Behaviour:
- Reset (rst=1, async): pc_addr=RESET_PC, ifid_inst=0, ifid_pc4=0, ifid_valid=0, halted=0, fetch_count=0, state=RUN.
- Cycle model: pc_addr is registered. The ROM returns inst_in in the same cycle. On the rising edge the IF/ID latch captures inst_in and pc_addr+4, and the PC advances. Fetch-to-decode latency is 1 cycle.
- Targets are computed from ifid_pc4 (decode's instruction):
  - branch target = ifid_pc4 + (sign_extend(branch_imm) << 2), modulo 2^32.
  - jump target = {ifid_pc4[31:28], jump_index, 2'b00}.
- State RUN, per-edge priority (highest first):
  1. jump=1: PC <= jump target; IF/ID <= bubble (inst=0, pc4=0, valid=0).
  2. branch_taken=1 (jump=0): PC <= branch target; IF/ID <= bubble.
  3. stall=1: PC and IF/ID hold; fetch_count holds.
  4. PC >= ROM_WORDS*4: state <= HALT; IF/ID <= bubble; PC holds.
  5. Otherwise: PC <= PC+4; IF/ID <= {inst_in, PC+4, valid=1}; fetch_count += 1.
- Redirect (jump/branch) overrides a simultaneous stall. Jump overrides branch if both are asserted.
- A redirect to an out-of-range target is accepted. HALT is taken on the following edge through rule 4.
- State HALT:
  - halted=1; IF/ID bubble each edge; PC holds; stall, jump and branch are ignored.
  - halt_clr=1: PC <= RESET_PC, state <= RUN, halted <= 0. fetch_count is not cleared.
- fetch_count wraps modulo 2^CNT_W with no saturation.
- PC+4 wraps modulo 2^32.
- pc_addr[1:0] is always 00 because all targets are word-aligned by construction.
- Reset asserted mid-operation clears everything immediately, including mid-stall and in HALT.

Test Plan:
- Reset, then 4 free-running edges:
  - pc_addr goes 0x0, 0x4, 0x8, 0xC, 0x10.
  - ifid_inst goes 0x00000000, 0x3c010001, 0x3c020002, 0x00411422 with ifid_pc4 = 0x4, 0x8, 0xC and valid=1.
  - fetch_count=4.
- stall=1 for 2 cycles at pc_addr=0x14 -> pc_addr stays 0x14, ifid_inst stays 0x00233022, fetch_count unchanged. After release, the next edge latches 0x8c640001.
- branch_taken=1, branch_imm=16'h0004, with ifid_pc4=0x30 -> next pc_addr=0x40, ifid_valid=0 for 1 cycle. branch_imm=16'hFFFC -> target 0x20.
- jump=1 and branch_taken=1 together, jump_index=26'h0000002, ifid_pc4=0x10 -> pc_addr=0x8 (jump wins), bubble latched. The same case with stall=1 still redirects.
- Free run to pc_addr=0x80 (ROM_WORDS=32):
  - next edge: halted=1, valid=0, PC holds 0x80 for 5 cycles despite jump pulses.
  - halt_clr pulse: pc_addr=0x0, halted=0.
- Assert rst asynchronously mid-cycle while stalled at 0x1C -> outputs clear without a clock edge. After deassert, fetch resumes from 0x0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID latch, with branch/jump redirect, stall and out-of-range halt.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             halt_clr,
    input  logic [31:0]      inst_in,
    output logic [31:0]      pc_addr,
    output logic [31:0]      ifid_inst,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    // One bit wider than the PC so a limit of 2^32 bytes still compares correctly.
    localparam logic [32:0] PC_LIMIT = 33'(ROM_WORDS) * 33'd4;

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        out_of_range;

    // Redirect targets come from the instruction sitting in decode, not the PC.
    assign pc_plus4      = pc_addr + 32'd4;
    assign branch_target = ifid_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_target   = {ifid_pc4[31:28], jump_index, 2'b00};
    assign out_of_range  = {1'b0, pc_addr} >= PC_LIMIT;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of pc_addr/ifid_pc4, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc_addr     <= RESET_PC;
            ifid_inst   <= 32'h0;
            ifid_pc4    <= 32'h0;
            ifid_valid  <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (jump) begin
                        pc_addr    <= jump_target;
                        ifid_inst  <= 32'h0;
                        ifid_pc4   <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else if (branch_taken) begin
                        pc_addr    <= branch_target;
                        ifid_inst  <= 32'h0;
                        ifid_pc4   <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else if (stall) begin
                        pc_addr    <= pc_addr;
                    end else if (out_of_range) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        ifid_inst  <= 32'h0;
                        ifid_pc4   <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else begin
                        pc_addr     <= pc_plus4;
                        ifid_inst   <= inst_in;
                        ifid_pc4    <= pc_plus4;
                        ifid_valid  <= 1'b1;
                        fetch_count <= fetch_count + 1'b1;
                    end
                end
                HALT: begin
                    ifid_inst  <= 32'h0;
                    ifid_pc4   <= 32'h0;
                    ifid_valid <= 1'b0;
                    if (halt_clr) begin
                        state   <= RUN;
                        halted  <= 1'b0;
                        pc_addr <= RESET_PC;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver pushes model predictions per edge,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int          ROM_WORDS = 32;
    localparam int          CNT_W     = 4;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [31:0]      pc4;
        logic             valid;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             branch_taken = 1'b0;
    logic [15:0]      branch_imm = 16'h0;
    logic             jump = 1'b0;
    logic [25:0]      jump_index = 26'h0;
    logic             halt_clr = 1'b0;
    logic [31:0]      inst_in;
    logic [31:0]      pc_addr;
    logic [31:0]      ifid_inst;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    if_stage #(.RESET_PC(RESET_PC), .ROM_WORDS(ROM_WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index),
        .halt_clr(halt_clr), .inst_in(inst_in), .pc_addr(pc_addr),
        .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [ROM_WORDS];
    assign inst_in = (pc_addr < 32'(ROM_WORDS * 4)) ? rom[pc_addr[6:2]] : 32'hdead_beef;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model state, in the terms the decode stage sees.
    logic [31:0]      m_pc, m_inst, m_pc4;
    logic             m_valid, m_halt;
    int               m_cnt;

    function automatic obs_t dut_obs();
        return '{pc: pc_addr, inst: ifid_inst, pc4: ifid_pc4, valid: ifid_valid,
                 halted: halted, cnt: fetch_count};
    endfunction

    function automatic obs_t model_obs();
        return '{pc: m_pc, inst: m_inst, pc4: m_pc4, valid: m_valid,
                 halted: m_halt, cnt: CNT_W'(m_cnt % (1 << CNT_W))};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got pc=%h inst=%h pc4=%h v=%b h=%b cnt=%0d want pc=%h inst=%h pc4=%h v=%b h=%b cnt=%0d",
                     name, $time, got.pc, got.inst, got.pc4, got.valid, got.halted, got.cnt,
                     want.pc, want.inst, want.pc4, want.valid, want.halted, want.cnt);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_inst = 0; m_pc4 = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
    endtask

    task automatic bubble();
        m_inst = 0; m_pc4 = 0; m_valid = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("edge", dut_obs(), exp_q.pop_front());
    end

    // Drive one edge's inputs, predict its outcome, and wait until it has been checked.
    task automatic step(input logic s, input logic b, input logic [15:0] imm,
                        input logic j, input logic [25:0] idx, input logic clr);
        stall = s; branch_taken = b; branch_imm = imm;
        jump = j; jump_index = idx; halt_clr = clr;
        if (m_halt) begin
            bubble();
            if (clr) begin m_pc = RESET_PC; m_halt = 0; end
        end else if (j) begin
            m_pc = {m_pc4[31:28], idx, 2'b00}; bubble();
        end else if (b) begin
            m_pc = m_pc4 + 32'($signed(imm) * 4); bubble();
        end else if (s) begin
            // everything holds
        end else if (m_pc >= ROM_WORDS * 4) begin
            m_halt = 1; bubble();
        end else begin
            m_inst = rom[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_cnt++;
        end
        exp_q.push_back(model_obs());
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic free();
        step(0, 0, 16'h0, 0, 26'h0, 0);
    endtask

    task automatic run_until_pc4(input logic [31:0] target);
        int n = 0;
        while (m_pc4 !== target && n < 200) begin free(); n++; end
        checks++;
        if (m_pc4 !== target) begin
            errors++;
            $display("FAIL run_until_pc4 got %h required %h", m_pc4, target);
        end
    endtask

    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'h2000_0000 | 32'(i * 32'h0101);
        rom[0] = 32'h3c01_0001; rom[1] = 32'h3c02_0002; rom[2] = 32'h0041_1422;
        rom[4] = 32'h0023_3022; rom[5] = 32'h8c64_0001;

        model_reset();
        #3;
        check("reset", dut_obs(), model_obs());
        @(negedge clk); #1;
        rst = 1'b0;

        // Sequential fetch, then stall at 0x14.
        repeat (5) free();
        step(1, 0, 16'h0, 0, 26'h0, 0);
        step(1, 0, 16'h0, 0, 26'h0, 0);
        free();

        // Branch backwards and forwards.
        run_until_pc4(32'h24);
        step(0, 1, 16'hFFFC, 0, 26'h0, 0);
        run_until_pc4(32'h30);
        step(0, 1, 16'h0004, 0, 26'h0, 0);
        free();

        // Jump beats branch, and redirect beats stall.
        step(0, 0, 16'h0, 1, 26'h0, 0);
        run_until_pc4(32'h10);
        step(0, 1, 16'h0010, 1, 26'h2, 0);
        run_until_pc4(32'h10);
        step(1, 1, 16'h0010, 1, 26'h2, 0);

        // Run off the end of ROM, sit in HALT ignoring redirects, then clear.
        begin
            int n = 0;
            while (m_pc !== 32'h80 && n < 200) begin free(); n++; end
        end
        free();
        for (int i = 0; i < 5; i++) step(i[0], 1, 16'h0, 1, 26'h1, 0);
        step(0, 0, 16'h0, 0, 26'h0, 1);

        // Randomised traffic, including out-of-range redirects and count wrap.
        for (int i = 0; i < 400; i++) begin
            logic r_s, r_b, r_j, r_c;
            logic [15:0] r_imm;
            logic [25:0] r_idx;
            r_s   = ($urandom_range(0, 9) < 2);
            r_b   = ($urandom_range(0, 9) < 1);
            r_j   = ($urandom_range(0, 19) < 1);
            r_c   = ($urandom_range(0, 2) == 0);
            r_imm = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($signed(6'($urandom)));
            r_idx = 26'($urandom_range(0, 40));
            step(r_s, r_b, r_imm, r_j, r_idx, r_c);
        end
        if (m_halt) step(0, 0, 16'h0, 0, 26'h0, 1);

        // Stall at 0x1C, then async reset between edges.
        step(0, 0, 16'h0, 1, 26'h7, 0);
        step(1, 0, 16'h0, 0, 26'h0, 0);
        step(1, 0, 16'h0, 0, 26'h0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        check("async_reset", dut_obs(), model_obs());
        @(negedge clk); #1;
        check("reset_hold", dut_obs(), model_obs());
        rst = 1'b0;
        stall = 1'b0;
        repeat (3) free();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
